// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Sequencing controller for the multi-cycle 64-bit MIPS datapath. The
// datapath has one shared memory port plus IR, register file, ALU and PC.
// The controller reads the opcode held in the IR and walks the datapath
// through fetch, decode, execute, memory and writeback. It waits for the
// memory ready handshake. It reports illegal opcodes and memory timeouts
// through a sticky error code.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   run_i          allows a new instruction fetch to start
//   opcode_i       IR[31:26], valid from the cycle after the IR write
//   zero_i         ALU zero flag
//   mem_ready_i    memory access completes this cycle
//   PCWrite_o .. MemToReg_o   single-bit datapath controls
//   ALUSrcB_o      00 reg, 01 const 4, 10 sign-extended imm, 11 imm<<2
//   ALUOp_o        00 add, 01 subtract, 10 funct field
//   PCSrc_o        00 ALU result, 01 ALUOut, 10 jump target
//   retire_o       one-cycle pulse on the last cycle of an instruction
//   err_o          sticky: 00 none, 01 illegal opcode, 10 memory timeout
//   state_o        current state, for debug
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl #(
    parameter int OPW     = 6,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           run_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           zero_i,
    input  logic           mem_ready_i,
    output logic           PCWrite_o,
    output logic           IRWrite_o,
    output logic           IorD_o,
    output logic           RegDst_o,
    output logic           RegWrite_o,
    output logic           ALUSrcA_o,
    output logic           MemRead_o,
    output logic           MemWrite_o,
    output logic           MemToReg_o,
    output logic [1:0]     ALUSrcB_o,
    output logic [1:0]     ALUOp_o,
    output logic [1:0]     PCSrc_o,
    output logic           retire_o,
    output logic [1:0]     err_o,
    output logic [3:0]     state_o
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);

    // The wait counter holds the number of earlier wait cycles. The timeout
    // fires on the TIMEOUT-th consecutive wait cycle, so the counter never
    // needs to hold TIMEOUT itself.
    localparam int             CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]  TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_ADDIEX = 4'd9,
        ST_ADDIWB = 4'd10,
        ST_BRANCH = 4'd11,
        ST_JUMP   = 4'd12,
        ST_ERROR  = 4'd13
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      err_q, err_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic            waiting;
    logic            timeoutHit;

    // State register plus the registers that travel with it: sticky error,
    // latched opcode and memory wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            err_q   <= 2'b00;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // A cycle counts as a wait cycle when a memory access is pending and
    // memory has not answered yet. A fetch is pending only while run_i is
    // high.
    assign waiting    = (((state_q == ST_FETCH) && run_i) ||
                         (state_q == ST_MEMRD) || (state_q == ST_MEMWR)) && !mem_ready_i;
    assign timeoutHit = (TIMEOUT != 0) && waiting && (wait_q == TO_LAST);

    // Next-state logic. mem_ready_i is tested before the timeout, so a
    // late ready still completes the access. The wait counter clears when
    // memory answers, when the state changes or when a fetch is abandoned.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        op_d    = op_q;
        case (state_q)
            ST_RST:    state_d = ST_FETCH;
            ST_FETCH: begin
                if (run_i) begin
                    if (mem_ready_i)     state_d = ST_DECODE;
                    else if (timeoutHit) begin
                        state_d = ST_ERROR;
                        err_d   = 2'b10;
                    end
                end
            end
            ST_DECODE: begin
                op_d = opcode_i;
                case (opcode_i)
                    OP_LW, OP_SW:   state_d = ST_MEMADR;
                    OP_RTYPE:       state_d = ST_EXEC;
                    OP_ADDI:        state_d = ST_ADDIEX;
                    OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                    OP_J:           state_d = ST_JUMP;
                    default: begin
                        state_d = ST_ERROR;
                        err_d   = 2'b01;
                    end
                endcase
            end
            ST_MEMADR: state_d = (op_q == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (mem_ready_i)     state_d = ST_MEMWB;
                else if (timeoutHit) begin
                    state_d = ST_ERROR;
                    err_d   = 2'b10;
                end
            end
            ST_MEMWR: begin
                if (mem_ready_i)     state_d = ST_FETCH;
                else if (timeoutHit) begin
                    state_d = ST_ERROR;
                    err_d   = 2'b10;
                end
            end
            ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ERROR:  state_d = ST_ERROR;
            default:   state_d = ST_ERROR;
        endcase
        wait_d = (waiting && (state_d == state_q)) ? wait_q + CW'(1) : '0;
    end

    // Output decode. Outputs are mostly Moore. FETCH uses run_i and
    // mem_ready_i, MEMWR retires on mem_ready_i, and BRANCH sets PCWrite
    // from the latched opcode and zero_i.
    always_comb begin
        PCWrite_o  = 1'b0;
        IRWrite_o  = 1'b0;
        IorD_o     = 1'b0;
        RegDst_o   = 1'b0;
        RegWrite_o = 1'b0;
        ALUSrcA_o  = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        MemToReg_o = 1'b0;
        ALUSrcB_o  = 2'b00;
        ALUOp_o    = 2'b00;
        PCSrc_o    = 2'b00;
        retire_o   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (run_i) begin
                    MemRead_o = 1'b1;
                    ALUSrcB_o = 2'b01;
                    IRWrite_o = mem_ready_i;
                    PCWrite_o = mem_ready_i;
                end
            end
            ST_DECODE: ALUSrcB_o = 2'b11;
            ST_MEMADR, ST_ADDIEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            ST_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite_o = 1'b1;
                MemToReg_o = 1'b1;
                retire_o   = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
                retire_o   = mem_ready_i;
            end
            ST_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b10;
            end
            ST_ALUWB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
                retire_o   = 1'b1;
            end
            ST_ADDIWB: begin
                RegWrite_o = 1'b1;
                retire_o   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 2'b01;
                PCSrc_o   = 2'b01;
                retire_o  = 1'b1;
                PCWrite_o = ((op_q == OP_BEQ) && zero_i) || ((op_q == OP_BNE) && !zero_i);
            end
            ST_JUMP: begin
                PCSrc_o   = 2'b10;
                PCWrite_o = 1'b1;
                retire_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign err_o   = err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Testbench for mips_multicycle_ctrl. The model works one instruction at a
// time. For the chosen opcode and memory wait lengths it works out the
// sequence of states, control vectors and error codes that the instruction
// must produce. It drives run/mem_ready to match and compares every cycle.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    localparam int TIMEOUT = 16;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;

    logic       clk;
    logic       rstN;
    logic       runI;
    logic [5:0] opcodeI;
    logic       zeroI;
    logic       memReadyI;
    logic       pcWrite, irWrite, iorD, regDst, regWrite, aluSrcA;
    logic       memRead, memWrite, memToReg, retire;
    logic [1:0] aluSrcB, aluOp, pcSrc, errO;
    logic [3:0] stateO;
    logic [15:0] ctrlObs;

    int         checks = 0;
    int         errors = 0;
    logic [5:0] curOp;
    bit         curZero;

    mips_multicycle_ctrl #(.OPW(6), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rstN),
        .run_i       (runI),
        .opcode_i    (opcodeI),
        .zero_i      (zeroI),
        .mem_ready_i (memReadyI),
        .PCWrite_o   (pcWrite),
        .IRWrite_o   (irWrite),
        .IorD_o      (iorD),
        .RegDst_o    (regDst),
        .RegWrite_o  (regWrite),
        .ALUSrcA_o   (aluSrcA),
        .MemRead_o   (memRead),
        .MemWrite_o  (memWrite),
        .MemToReg_o  (memToReg),
        .ALUSrcB_o   (aluSrcB),
        .ALUOp_o     (aluOp),
        .PCSrc_o     (pcSrc),
        .retire_o    (retire),
        .err_o       (errO),
        .state_o     (stateO)
    );

    assign ctrlObs = {pcWrite, irWrite, iorD, regDst, regWrite, aluSrcA, memRead,
                      memWrite, memToReg, aluSrcB, aluOp, pcSrc, retire};

    // Free-running clock. Rising edges fall at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs one control vector in the same field order as ctrlObs.
    function automatic logic [15:0] ctl(input bit pcw, irw, iord, rdst, rwr, srca,
                                        mrd, mwr, m2r, input logic [1:0] srcb, aop,
                                        psrc, input bit ret);
        return {pcw, irw, iord, rdst, rwr, srca, mrd, mwr, m2r, srcb, aop, psrc, ret};
    endfunction

    // The single comparison point. Every check goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drives one cycle of inputs just after the clock edge, then waits for
    // the falling edge so the outputs can settle.
    task automatic applyStimulus(input bit run, input bit ready);
        runI      = run;
        memReadyI = ready;
        zeroI     = curZero;
        opcodeI   = curOp;
        @(negedge clk);
    endtask

    // Runs one cycle and checks state, controls and error code against the
    // model, then moves to just after the next rising edge.
    task automatic cyc(input bit run, input bit ready, input logic [3:0] st,
                       input logic [15:0] c, input logic [1:0] e, input string tag);
        applyStimulus(run, ready);
        checkOutput({tag, "/state"}, 32'(stateO), 32'(st));
        checkOutput({tag, "/ctrl"}, 32'(ctrlObs), 32'(c));
        checkOutput({tag, "/err"}, 32'(errO), 32'(e));
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between clock edges and checks that it acts at once.
    // After release the FSM must be in FETCH at the next edge.
    task automatic doReset();
        #2;
        runI      = 1'b1;
        memReadyI = 1'b0;
        rstN      = 1'b0;
        #1;
        checkOutput("reset/state", 32'(stateO), 32'd0);
        checkOutput("reset/ctrl", 32'(ctrlObs), 32'd0);
        checkOutput("reset/err", 32'(errO), 32'd0);
        @(posedge clk);
        #2;
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset/fetch", 32'(stateO), 32'd1);
    endtask

    // ERROR is terminal. Its outputs stay zero and err holds, whatever the
    // inputs do. Only a reset gets out.
    task automatic expectError(input logic [1:0] code);
        for (int i = 0; i < 3; i++)
            cyc(1'($urandom), 1'($urandom), 4'd13, 16'd0, code, "error");
        doReset();
    endtask

    // One memory wait phase. The access takes `waits` not-ready cycles,
    // then a ready cycle if `finish` is set. The access times out on the
    // TIMEOUT-th consecutive not-ready cycle.
    task automatic waitPhase(input logic [3:0] st, input logic [15:0] wc, input logic [15:0] rc,
                             input int waits, input bit finish, output bit to);
        to = 1'b0;
        for (int i = 1; i <= waits; i++) begin
            cyc(1'b1, 1'b0, st, wc, 2'b00, "wait");
            if (i == TIMEOUT) begin
                to = 1'b1;
                return;
            end
        end
        if (finish) cyc(1'b1, 1'b1, st, rc, 2'b00, "ready");
    endtask

    // Reference model for one instruction. It produces the expected cycle
    // by cycle behaviour from the opcode, the zero flag and the memory
    // wait lengths.
    task automatic runInstr(input logic [5:0] op, input bit z, input int fw,
                            input int dropW, input int mw);
        bit to;
        logic [15:0] fetchWait = ctl(0,0,0,0,0,0,1,0,0,2'b01,2'b00,2'b00,0);
        logic [15:0] fetchDone = ctl(1,1,0,0,0,0,1,0,0,2'b01,2'b00,2'b00,0);
        logic [15:0] adrCtl    = ctl(0,0,0,0,0,1,0,0,0,2'b10,2'b00,2'b00,0);
        logic [15:0] memWrWait = ctl(0,0,1,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
        logic [15:0] memWrDone = ctl(0,0,1,0,0,0,0,1,0,2'b00,2'b00,2'b00,1);
        logic [15:0] memRdCtl  = ctl(0,0,1,0,0,0,1,0,0,2'b00,2'b00,2'b00,0);
        bit take;
        curOp   = op;
        curZero = z;
        for (int i = 0; i < int'($urandom_range(0, 1)); i++)
            cyc(1'b0, 1'($urandom), 4'd1, 16'd0, 2'b00, "idle");
        if (dropW > 0) begin
            waitPhase(4'd1, fetchWait, fetchDone, dropW, 1'b0, to);
            if (to) begin expectError(2'b10); return; end
            cyc(1'b0, 1'b0, 4'd1, 16'd0, 2'b00, "drop");
        end
        waitPhase(4'd1, fetchWait, fetchDone, fw, 1'b1, to);
        if (to) begin expectError(2'b10); return; end
        cyc(1'($urandom), 1'($urandom), 4'd2, ctl(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0),
            2'b00, "decode");
        case (op)
            OP_LW: begin
                cyc(1'($urandom), 1'($urandom), 4'd3, adrCtl, 2'b00, "memadr");
                waitPhase(4'd4, memRdCtl, memRdCtl, mw, 1'b1, to);
                if (to) begin expectError(2'b10); return; end
                cyc(1'($urandom), 1'($urandom), 4'd5,
                    ctl(0,0,0,0,1,0,0,0,1,2'b00,2'b00,2'b00,1), 2'b00, "memwb");
            end
            OP_SW: begin
                cyc(1'($urandom), 1'($urandom), 4'd3, adrCtl, 2'b00, "memadr");
                waitPhase(4'd6, memWrWait, memWrDone, mw, 1'b1, to);
                if (to) begin expectError(2'b10); return; end
            end
            OP_ADD: begin
                cyc(1'($urandom), 1'($urandom), 4'd7,
                    ctl(0,0,0,0,0,1,0,0,0,2'b00,2'b10,2'b00,0), 2'b00, "exec");
                cyc(1'($urandom), 1'($urandom), 4'd8,
                    ctl(0,0,0,1,1,0,0,0,0,2'b00,2'b00,2'b00,1), 2'b00, "aluwb");
            end
            OP_ADDI: begin
                cyc(1'($urandom), 1'($urandom), 4'd9, adrCtl, 2'b00, "addiex");
                cyc(1'($urandom), 1'($urandom), 4'd10,
                    ctl(0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,1), 2'b00, "addiwb");
            end
            OP_BEQ, OP_BNE: begin
                take = (op == OP_BEQ) ? z : !z;
                cyc(1'($urandom), 1'($urandom), 4'd11,
                    ctl(take,0,0,0,0,1,0,0,0,2'b00,2'b01,2'b01,1), 2'b00, "branch");
            end
            OP_J: cyc(1'($urandom), 1'($urandom), 4'd12,
                      ctl(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1), 2'b00, "jump");
            default: expectError(2'b01);
        endcase
    endtask

    initial begin
        logic [5:0] legal [7];
        logic [5:0] illegal [5];
        int fw, dropW, mw, r;
        legal   = '{OP_ADD, OP_ADDI, OP_LW, OP_SW, OP_J, OP_BEQ, OP_BNE};
        illegal = '{6'b111111, 6'b000001, 6'b100000, 6'b001001, 6'b010000};
        rstN      = 1'b1;
        runI      = 1'b0;
        memReadyI = 1'b0;
        zeroI     = 1'b0;
        opcodeI   = '0;
        curOp     = '0;
        curZero   = 1'b0;
        #1;
        doReset();

        // Directed cases: plain add, lw with a slow memory, both branch
        // senses, illegal opcode, sw timeout, ready on the last allowed
        // cycle, and a fetch abandoned part way through.
        runInstr(OP_ADD, 1'b0, 0, 0, 0);
        runInstr(OP_LW, 1'b0, 0, 0, 3);
        runInstr(OP_BEQ, 1'b1, 0, 0, 0);
        runInstr(OP_BNE, 1'b1, 0, 0, 0);
        runInstr(6'b111111, 1'b0, 0, 0, 0);
        runInstr(OP_SW, 1'b0, 0, 0, 20);
        runInstr(OP_SW, 1'b0, 0, 0, TIMEOUT - 1);
        runInstr(OP_ADD, 1'b0, 10, 10, 0);
        runInstr(OP_LW, 1'b0, TIMEOUT, 0, 0);

        // Random instruction stream.
        for (int n = 0; n < 120; n++) begin
            r     = int'($urandom_range(0, 11));
            fw    = int'($urandom_range(0, 2));
            dropW = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 12)) : 0;
            mw    = int'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) fw = TIMEOUT;
            case ($urandom_range(0, 11))
                0:       mw = TIMEOUT - 1;
                1:       mw = int'($urandom_range(TIMEOUT, TIMEOUT + 2));
                default: ;
            endcase
            runInstr((r == 11) ? illegal[$urandom_range(0, 4)] : legal[r % 7],
                     1'($urandom), fw, dropW, mw);
        end

        // Reset asserted while a store is waiting on memory.
        curOp = OP_SW;
        cyc(1'b1, 1'b1, 4'd1, ctl(1,1,0,0,0,0,1,0,0,2'b01,2'b00,2'b00,0), 2'b00, "rst_fetch");
        cyc(1'b1, 1'b0, 4'd2, ctl(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), 2'b00, "rst_decode");
        cyc(1'b1, 1'b0, 4'd3, ctl(0,0,0,0,0,1,0,0,0,2'b10,2'b00,2'b00,0), 2'b00, "rst_memadr");
        cyc(1'b1, 1'b0, 4'd6, ctl(0,0,1,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), 2'b00, "rst_memwr");
        doReset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
